// File: rtl/fetch.sv
// fetch: instruction fetch unit sitting on the read side of the write-back
// stage's next-PC path. A next PC arrives from write-back and is fetched
// over a req/ack memory handshake. The fetched word is then offered to
// decode over a valid/ready handshake. One instruction is in flight at a
// time, and at most one redirect is held pending.
//
// Parameters:
//   RESET_PC       PC fetched first after reset.
//
// Ports:
//   clk            core clock, rising-edge
//   reset          synchronous, active-high
//   pc_wd_i        next PC from write-back
//   pc_wd_valid_i  one-cycle strobe qualifying pc_wd_i
//   mem_addr_o     word-aligned instruction read address
//   mem_req_o      read request, held until acked
//   mem_ack_i      read complete, mem_i valid this cycle
//   mem_i          instruction word from memory
//   ir_o           fetched instruction to decode
//   pc_o           PC of ir_o
//   ir_valid_o     ir_o/pc_o valid
//   ir_ready_i     decode accepts
//   busy_o         a fetch is in progress or an instruction is held
//   misalign_o     ir_o is a NOP substituted for a misaligned PC
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a
// misaligned PC does not touch memory. Instead, a NOP is delivered with
// misalign_o set. When it is undefined, the low PC bits are dropped from
// the address and misalign_o stays 0.

module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_wd_i,
  input  logic        pc_wd_valid_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic        ir_valid_o,
  input  logic        ir_ready_i,
  output logic        busy_o,
  output logic        misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        misalign_q, misalign_d;
  logic        pc_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  // State register. Reset lands in REQ, so the first cycle after reset
  // already requests RESET_PC. Reset also drops any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0;
      pend_v_q   <= 1'b0;
      ir_q       <= 32'h0;
      pc_out_q   <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_v_q   <= pend_v_d;
      ir_q       <= ir_d;
      pc_out_q   <= pc_out_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_v_d   = pend_v_q;
    ir_d       = ir_q;
    pc_out_d   = pc_out_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (pc_wd_valid_i) begin
          pc_d    = pc_wd_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (pc_misaligned) begin
          // No memory access. A NOP is substituted, and any ack is ignored.
          ir_d       = NOP;
          pc_out_d   = pc_q;
          misalign_d = 1'b1;
          state_d    = HOLD;
          if (pc_wd_valid_i) begin
            pend_v_d  = 1'b1;
            pend_pc_d = pc_wd_i;
          end
        end else if (mem_ack_i) begin
          // A strobe coinciding with the ack counts as pending, so it
          // discards the returned word just like an older redirect.
          if (pend_v_q || pc_wd_valid_i) begin
            pc_d     = pc_wd_valid_i ? pc_wd_i : pend_pc_q;
            pend_v_d = 1'b0;
          end else begin
            ir_d       = mem_i;
            pc_out_d   = pc_q;
            misalign_d = 1'b0;
            state_d    = HOLD;
          end
        end else if (pc_wd_valid_i) begin
          pend_v_d  = 1'b1;
          pend_pc_d = pc_wd_i;
        end
      end
      HOLD: begin
        if (ir_ready_i) begin
          misalign_d = 1'b0;
          if (pc_wd_valid_i) begin
            pc_d     = pc_wd_i;
            pend_v_d = 1'b0;
            state_d  = REQ;
          end else if (pend_v_q) begin
            pc_d     = pend_pc_q;
            pend_v_d = 1'b0;
            state_d  = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (pc_wd_valid_i) begin
          // The held instruction is kept; the redirect waits its turn.
          pend_v_d  = 1'b1;
          pend_pc_d = pc_wd_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. These are forced to their reset values while reset is high,
  // so nothing stale leaks out during the reset cycle itself.
  always_comb begin
    mem_req_o  = 1'b0;
    ir_valid_o = 1'b0;
    busy_o     = 1'b0;
    misalign_o = 1'b0;
    ir_o       = 32'h0;
    pc_o       = RESET_PC;
    mem_addr_o = {RESET_PC[31:2], 2'b00};
    if (!reset) begin
      mem_req_o  = (state_q == REQ) && !pc_misaligned;
      ir_valid_o = (state_q == HOLD);
      busy_o     = (state_q == REQ) || (state_q == HOLD);
      misalign_o = misalign_q;
      ir_o       = ir_q;
      pc_o       = pc_out_q;
      mem_addr_o = {pc_q[31:2], 2'b00};
    end
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch unit: the read side of the write-back stage's next-PC path. It accepts the next PC from write-back, issues one 32-bit instruction read to memory over a req/ack handshake, and presents the instruction and its PC to decode over a valid/ready handshake. It keeps one instruction in flight and holds at most one pending redirect, matching the core's multi-cycle execution.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk`  in  1: core clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc_wd_i`  in  32: next PC from write-back.
- `pc_wd_valid_i`  in  1: one-cycle strobe qualifying `pc_wd_i`.
- `mem_addr_o`  out  32: instruction read address, word-aligned.
- `mem_req_o`  out  1: read request, held until acked.
- `mem_ack_i`  in  1: read complete; `mem_i` valid this cycle.
- `mem_i`  in  32: instruction word.
- `ir_o`  out  32: fetched instruction to decode.
- `pc_o`  out  32: PC of `ir_o`.
- `ir_valid_o`  out  1: `ir_o`/`pc_o` valid.
- `ir_ready_i`  in  1: decode accepts.
- `busy_o`  out  1: high in REQ or HOLD.
- `misalign_o`  out  1: current `ir_o` came from a misaligned PC. Only meaningful with the macro; otherwise tied 0.

## Operation
- Registers: `pc`, `pend_pc`, `pend_v`, `ir_o`, `pc_o`, and a 2-bit state.
- State IDLE: `mem_req_o`=0, `ir_valid_o`=0. When `pc_wd_valid_i`=1: `pc`<=`pc_wd_i`, go to REQ.
- State REQ: `mem_req_o`=1, `mem_addr_o`={`pc`[31:2],2'b00}.
  - On `mem_ack_i` with `pend_v`=0: `ir_o`<=`mem_i`, `pc_o`<=`pc`, go to HOLD.
  - On `mem_ack_i` with `pend_v`=1: discard `mem_i`, `pc`<=`pend_pc`, clear `pend_v`, stay in REQ (new request).
- State HOLD: `ir_valid_o`=1, and `ir_o`/`pc_o` are stable until the handshake (`ir_valid_o`&`ir_ready_i`).
  - On the handshake with `pend_v`=1: `pc`<=`pend_pc`, clear `pend_v`, go to REQ.
  - On the handshake with `pend_v`=0: go to IDLE.
- Redirect outside IDLE: `pc_wd_valid_i` in REQ or HOLD sets `pend_v` and `pend_pc`<=`pc_wd_i`. A later strobe overwrites it (last wins).
- Simultaneous strobe and handshake in HOLD: go to REQ with `pc`<=`pc_wd_i`; `pend_v` stays 0.
- Simultaneous strobe and `mem_ack_i` in REQ: the strobe counts as pending, so the ack is discarded and the refetch uses `pc_wd_i`.
- `mem_ack_i` while `mem_req_o`=0 is ignored.
- The HOLD instruction is never dropped or altered by a redirect.
- `busy_o` = state is REQ or HOLD.

## Timing
- During reset: `mem_req_o`, `ir_valid_o`, `busy_o`, `misalign_o`, `ir_o`, `pend_v` = 0. `pc_o` = `mem_addr_o` = `RESET_PC`. State goes to REQ.
- First cycle after reset deasserts: `mem_req_o`=1 with `mem_addr_o`=`RESET_PC`.
- Reset mid-operation: abandon the in-flight fetch and any pending redirect. An ack arriving in the reset cycle is ignored.
- Strobe in IDLE at cycle K: `mem_req_o`=1 at K+1.
- Ack at cycle N: `ir_valid_o`=1 and `mem_req_o`=0 at N+1.
- Handshake at cycle M: `ir_valid_o`=0 at M+1, or `mem_req_o`=1 at M+1 if a redirect is pending.
- Zero-wait memory (ack the first cycle req is high) with decode always ready: one instruction every 3 cycles from the strobe.
- No combinational path from `mem_i` or `ir_ready_i` to any output.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - On entry to REQ with `pc`[1:0]≠0: no memory request is issued.
  - Next cycle: HOLD with `ir_o`=32'h0000_0013 (NOP), `pc_o`=`pc`, `misalign_o`=1.
  - `misalign_o` clears when leaving HOLD.
- Undefined: `pc`[1:0] is ignored (address forced to a word boundary), and `misalign_o` is constant 0.

## Test plan
- Reset release with `RESET_PC`=32'h100, memory acks 1 cycle after req with 32'h00500093 -> `ir_o`=32'h00500093, `pc_o`=32'h100, `ir_valid_o` high until `ir_ready_i`, then IDLE.
- Strobe `pc_wd_i`=32'h104 in IDLE, ack with 3 wait cycles, `ir_ready_i` held low 2 cycles -> `mem_addr_o`=32'h104; `ir_o` stable across the stall; `ir_valid_o` drops the cycle after acceptance.
- Strobe 32'h200 then 32'h300 during REQ, before the ack for 32'h104 -> first ack discarded, next request at 32'h300, delivered `pc_o`=32'h300, no instruction for 32'h104 or 32'h200.
- Strobe 32'h40 in the same cycle as the HOLD handshake -> held instruction accepted once, `mem_req_o`=1 next cycle at 32'h40.
- Reset asserted while `mem_req_o`=1 and ack arrives the same cycle -> all outputs at reset values, no `ir_valid_o`, refetch at `RESET_PC`.
- With `FETCH_ALIGN_CHECK_EN`, strobe 32'h102 -> no `mem_req_o`, `ir_o`=32'h00000013, `misalign_o`=1, `pc_o`=32'h102. Without the macro -> `mem_addr_o`=32'h100, `misalign_o`=0.
